// File: rtl/mdu_sched_if.sv
// Pipeline-control bundle between the MDU scheduler and the rest of the core.
interface mdu_sched_if;
  logic       E_start;
  logic [1:0] E_op;
  logic       D_use_mdu;
  logic       hazard_stall;
  logic       busy;
  logic       done;
  logic       stall;
  logic       pc_en;
  logic       fd_en;
  logic       de_flush;
  logic       em_enable;
  logic       em_flush;
  logic       err;

  // Scheduler side.
  modport slave (
    input  E_start, E_op, D_use_mdu, hazard_stall,
    output busy, done, stall, pc_en, fd_en, de_flush, em_enable, em_flush, err
  );

  // Pipeline / stimulus side.
  modport master (
    output E_start, E_op, D_use_mdu, hazard_stall,
    input  busy, done, stall, pc_en, fd_en, de_flush, em_enable, em_flush, err
  );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide busy-period sequencer plus pipeline stall/bubble generation.
module mdu_sched #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10,
  parameter int unsigned CNT_W      = 4
) (
  input  logic         clk,
  input  logic         reset,
  mdu_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             mdu_stall;
  logic             stall_int;

  // Signed and unsigned variants share the same latency, so E_op[0] is not needed.
  logic unused_op;
  assign unused_op = bus.E_op[0];

  // Busy-period FSM: load the latency on start, count down, pulse done on the last cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.E_start) begin
            busy_q <= 1'b1;
            if (bus.E_op[1]) begin
              state <= DIV;
              cnt   <= CNT_W'(DIV_CYCLES);
            end else begin
              state <= MUL;
              cnt   <= CNT_W'(MUL_CYCLES);
            end
          end
        end
        MUL, DIV: begin
          // A second start while computing is dropped and flagged.
          if (bus.E_start) begin
            err_q <= 1'b1;
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // E_start term stalls the dependent D-stage instr in the cycle before busy rises.
  assign mdu_stall = bus.D_use_mdu & (busy_q | bus.E_start);
  assign stall_int = bus.hazard_stall | mdu_stall;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.stall     = stall_int;
  assign bus.pc_en     = ~stall_int;
  assign bus.fd_en     = ~stall_int;
  assign bus.de_flush  = stall_int;
  assign bus.em_enable = 1'b1;
  assign bus.em_flush  = 1'b0;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched with a done-timing scoreboard.
module tb_mdu_sched;

  localparam int unsigned MUL_N = 5;
  localparam int unsigned DIV_N = 10;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   edge_cnt;
  int   sb[$];

  mdu_sched_if bus ();

  mdu_sched #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_W     (4)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each done pulse must land on the edge predicted when its start was driven.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(bus.done), 32'd0);
      end else begin
        chk("done_edge", 32'(edge_cnt), 32'(sb.pop_front()));
      end
    end
  end

  // Driven before the sampling edge: done expected N edges after that edge.
  task automatic start_op(input logic [1:0] op, input int unsigned n);
    bus.E_start = 1'b1;
    bus.E_op    = op;
    sb.push_back(edge_cnt + 1 + int'(n));
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    edge_cnt = 0;
    rst_n    = 1'b0;
    bus.E_start      = 1'b0;
    bus.E_op         = 2'b00;
    bus.D_use_mdu    = 1'b0;
    bus.hazard_stall = 1'b0;
    #3;
    // Reset state and idle control outputs.
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rst_fd_en", 32'(bus.fd_en), 32'd1);
    chk("rst_de_flush", 32'(bus.de_flush), 32'd0);
    chk("rst_em_enable", 32'(bus.em_enable), 32'd1);
    chk("rst_em_flush", 32'(bus.em_flush), 32'd0);
    bus.hazard_stall = 1'b1;
    #1;
    chk("rst_comb_stall", 32'(bus.stall), 32'd1);
    bus.hazard_stall = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // MULT: busy for exactly 5 cycles, done in the following one.
    start_op(2'b00, MUL_N);
    #1;
    chk("mul_no_stall", 32'(bus.stall), 32'd0);
    step();
    bus.E_start = 1'b0;
    chk("mul_busy0", 32'(bus.busy), 32'd1);
    for (int i = 1; i < 5; i++) begin
      step();
      chk("mul_busy", 32'(bus.busy), 32'd1);
      chk("mul_done_low", 32'(bus.done), 32'd0);
    end
    step();
    chk("mul_busy_end", 32'(bus.busy), 32'd0);
    chk("mul_done", 32'(bus.done), 32'd1);
    step();
    chk("mul_done_pulse", 32'(bus.done), 32'd0);

    // DIVU with a dependent D-stage MDU instruction held throughout.
    start_op(2'b11, DIV_N);
    bus.D_use_mdu = 1'b1;
    #1;
    chk("div_pre_stall", 32'(bus.stall), 32'd1);
    chk("div_pre_pc_en", 32'(bus.pc_en), 32'd0);
    chk("div_pre_fd_en", 32'(bus.fd_en), 32'd0);
    chk("div_pre_de_flush", 32'(bus.de_flush), 32'd1);
    step();
    bus.E_start = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("div_stall", 32'(bus.stall), 32'd1);
      chk("div_busy", 32'(bus.busy), 32'd1);
      if (i < 9) step();
    end
    step();
    chk("div_done", 32'(bus.done), 32'd1);
    chk("div_stall_drop", 32'(bus.stall), 32'd0);
    chk("div_pc_en", 32'(bus.pc_en), 32'd1);
    bus.D_use_mdu = 1'b0;

    // General hazard stall while idle.
    step();
    bus.hazard_stall = 1'b1;
    #1;
    chk("hz_stall", 32'(bus.stall), 32'd1);
    chk("hz_de_flush", 32'(bus.de_flush), 32'd1);
    chk("hz_pc_en", 32'(bus.pc_en), 32'd0);
    chk("hz_em_enable", 32'(bus.em_enable), 32'd1);
    chk("hz_busy", 32'(bus.busy), 32'd0);
    bus.hazard_stall = 1'b0;

    // Illegal restart during MULTU at cnt=3; hazard stall must not freeze counting.
    start_op(2'b01, MUL_N);
    step();
    bus.E_start = 1'b0;
    bus.hazard_stall = 1'b1;
    step();
    step();
    bus.hazard_stall = 1'b0;
    bus.E_start = 1'b1;
    bus.E_op    = 2'b10;
    step();
    bus.E_start = 1'b0;
    chk("ill_err", 32'(bus.err), 32'd1);
    chk("ill_busy1", 32'(bus.busy), 32'd1);
    step();
    chk("ill_busy2", 32'(bus.busy), 32'd1);
    step();
    chk("ill_busy_fall", 32'(bus.busy), 32'd0);
    chk("ill_done", 32'(bus.done), 32'd1);
    step();
    step();
    chk("ill_err_sticky", 32'(bus.err), 32'd1);

    // No false stall from a D-stage MDU instr when the unit is idle.
    bus.D_use_mdu = 1'b1;
    #1;
    chk("nofalse_stall", 32'(bus.stall), 32'd0);
    chk("nofalse_pc_en", 32'(bus.pc_en), 32'd1);
    bus.D_use_mdu = 1'b0;

    // Asynchronous reset mid-DIV at cnt=6 aborts without done.
    step();
    start_op(2'b10, DIV_N);
    step();
    bus.E_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_err_clr", 32'(bus.err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("abort_idle_busy", 32'(bus.busy), 32'd0);
      chk("abort_idle_done", 32'(bus.done), 32'd0);
    end
    chk("abort_pc_en", 32'(bus.pc_en), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
